// File: rtl/lc2k_pkg.sv
// rtl/lc2k_pkg.sv - shared types and constants for the LC2K unified-memory port arbiter
package lc2k_pkg;

  localparam int LC2K_ADDR_W = 16;
  localparam int LC2K_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } arb_owner_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/arb_perf_counters.sv
// rtl/arb_perf_counters.sv - saturating grant/conflict counters for mem_port_arbiter
// Instantiated by the top only when PERF_CNT_EN is defined.
module arb_perf_counters
  import lc2k_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_if_gnt,
  input  logic        i_d_gnt,
  input  logic        i_conflict,
  output logic [31:0] o_if_grant_cnt,
  output logic [31:0] o_d_grant_cnt,
  output logic [31:0] o_conflict_cnt
);

  logic [31:0] r_if_grant_cnt;
  logic [31:0] r_d_grant_cnt;
  logic [31:0] r_conflict_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_grant_cnt <= '0;
      r_d_grant_cnt  <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (i_if_gnt)   r_if_grant_cnt <= sat_inc32(r_if_grant_cnt);
      if (i_d_gnt)    r_d_grant_cnt  <= sat_inc32(r_d_grant_cnt);
      if (i_conflict) r_conflict_cnt <= sat_inc32(r_conflict_cnt);
    end
  end

  assign o_if_grant_cnt = r_if_grant_cnt;
  assign o_d_grant_cnt  = r_d_grant_cnt;
  assign o_conflict_cnt = r_conflict_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported LC2K memory between fetch and the MEM stage
// Defining PERF_CNT_EN adds ifGrantCnt/dGrantCnt/conflictCnt outputs.
module mem_port_arbiter
  import lc2k_pkg::*;
#(
  parameter int ADDR_W     = LC2K_ADDR_W,
  parameter int DATA_W     = LC2K_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic              ifGnt,
  output logic              ifValid,
  output logic [DATA_W-1:0] ifRdata,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWdata,
  output logic              dGnt,
  output logic              dValid,
  output logic [DATA_W-1:0] dRdata,
  output logic              memEn,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  output logic              busy
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]       ifGrantCnt,
  output logic [31:0]       dGrantCnt,
  output logic [31:0]       conflictCnt
`endif
);

  localparam int              SC_W       = $clog2(STARVE_MAX + 2);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
  localparam logic [2:0]      LAT_INIT   = 3'(MEM_LAT - 1);

  arb_state_e        r_state;
  arb_owner_e        r_owner;
  logic              r_we;
  logic [2:0]        r_lat_cnt;
  logic [SC_W-1:0]   r_starve_cnt;
  logic              r_if_valid;
  logic              r_d_valid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_idle;
  logic w_starved;
  logic w_if_gnt;
  logic w_d_gnt;

  // Grants are combinational so the memory strobe goes out in the grant cycle itself.
  assign w_idle    = (r_state == ARB_IDLE) && !reset;
  assign w_starved = ifReq && (r_starve_cnt == STARVE_LIM);
  assign w_d_gnt   = w_idle && dReq && !w_starved;
  assign w_if_gnt  = w_idle && ifReq && !w_d_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ARB_IDLE;
      r_owner      <= OWN_IF;
      r_we         <= 1'b0;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_if_valid   <= 1'b0;
      r_d_valid    <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;

      if (!ifReq || w_if_gnt) begin
        r_starve_cnt <= '0;
      end else if (w_d_gnt && (r_starve_cnt != STARVE_LIM)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end

      case (r_state)
        ARB_IDLE: begin
          if (w_if_gnt || w_d_gnt) begin
            r_state   <= ARB_WAIT;
            r_lat_cnt <= LAT_INIT;
            r_owner   <= w_d_gnt ? OWN_D : OWN_IF;
            r_we      <= w_d_gnt && dWe;
          end
        end
        ARB_WAIT: begin
          // Last wait cycle: memRdata is valid now, so capture it and raise valid for RESP.
          if (r_lat_cnt == 3'd0) begin
            r_state <= ARB_RESP;
            if (r_owner == OWN_D) begin
              r_d_valid <= 1'b1;
              r_d_rdata <= r_we ? '0 : memRdata;
            end else begin
              r_if_valid <= 1'b1;
              r_if_rdata <= memRdata;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
          end
        end
        ARB_RESP: r_state <= ARB_IDLE;
        default:  r_state <= ARB_IDLE;
      endcase
    end
  end

  assign ifGnt    = w_if_gnt;
  assign dGnt     = w_d_gnt;
  assign memEn    = w_if_gnt || w_d_gnt;
  assign memWe    = w_d_gnt && dWe;
  assign memAddr  = w_d_gnt ? dAddr : (w_if_gnt ? ifAddr : '0);
  assign memWdata = (w_d_gnt && dWe) ? dWdata : '0;
  assign ifValid  = r_if_valid;
  assign ifRdata  = r_if_rdata;
  assign dValid   = r_d_valid;
  assign dRdata   = r_d_rdata;
  assign busy     = (r_state != ARB_IDLE);

`ifdef PERF_CNT_EN
  logic w_conflict;
  assign w_conflict = w_idle && ifReq && dReq;

  arb_perf_counters u_perf (
    .clk            (clk),
    .reset          (reset),
    .i_if_gnt       (w_if_gnt),
    .i_d_gnt        (w_d_gnt),
    .i_conflict     (w_conflict),
    .o_if_grant_cnt (ifGrantCnt),
    .o_d_grant_cnt  (dGrantCnt),
    .o_conflict_cnt (conflictCnt)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (MEM_LAT 1 and 3 instances)
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        reset;
  logic        ifReq    [2];
  logic [15:0] ifAddr   [2];
  logic        ifGnt    [2];
  logic        ifValid  [2];
  logic [31:0] ifRdata  [2];
  logic        dReq     [2];
  logic        dWe      [2];
  logic [15:0] dAddr    [2];
  logic [31:0] dWdata   [2];
  logic        dGnt     [2];
  logic        dValid   [2];
  logic [31:0] dRdata   [2];
  logic        memEn    [2];
  logic        memWe    [2];
  logic [15:0] memAddr  [2];
  logic [31:0] memWdata [2];
  logic [31:0] memRdata [2];
  logic        busy     [2];
`ifdef PERF_CNT_EN
  logic [31:0] ifGrantCnt  [2];
  logic [31:0] dGrantCnt   [2];
  logic [31:0] conflictCnt [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .MEM_LAT    ((g == 0) ? 1 : 3),
      .STARVE_MAX (STARVE_MAX)
    ) dut (
      .clk      (clk),
      .reset    (reset),
      .ifReq    (ifReq[g]),
      .ifAddr   (ifAddr[g]),
      .ifGnt    (ifGnt[g]),
      .ifValid  (ifValid[g]),
      .ifRdata  (ifRdata[g]),
      .dReq     (dReq[g]),
      .dWe      (dWe[g]),
      .dAddr    (dAddr[g]),
      .dWdata   (dWdata[g]),
      .dGnt     (dGnt[g]),
      .dValid   (dValid[g]),
      .dRdata   (dRdata[g]),
      .memEn    (memEn[g]),
      .memWe    (memWe[g]),
      .memAddr  (memAddr[g]),
      .memWdata (memWdata[g]),
      .memRdata (memRdata[g]),
      .busy     (busy[g])
`ifdef PERF_CNT_EN
      ,
      .ifGrantCnt  (ifGrantCnt[g]),
      .dGrantCnt   (dGrantCnt[g]),
      .conflictCnt (conflictCnt[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // environment memory with its read delay line, and the reference model's own copy
  logic [31:0] env_mem [2][256];
  logic [31:0] ref_mem [2][256];
  logic [31:0] dly     [2][5];

  // transaction-level reference model: next free cycle, starvation count, one pending response
  int          m_free   [2];
  int          m_starve [2];
  int          m_due    [2];
  bit          m_pend   [2];
  bit          m_down   [2];
  logic [31:0] m_data   [2];

  bit          last_ig      [2];
  bit          last_dg      [2];
  bit          last_we      [2];
  int          last_gnt_cyc [2];
  int          last_iv_cyc  [2];
  logic [31:0] last_irdata  [2];
  logic [31:0] last_drdata  [2];
  int          dv_cnt       [2];
  byte         glog   [$];
  int          gcyc1  [$];
  int          ivcyc1 [$];

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      logic idle, eig, edg, ev;
      logic [7:0] a;
      idle = (cyc >= m_free[g]) && !reset;
      edg  = idle && dReq[g] && !(ifReq[g] && (m_starve[g] == STARVE_MAX));
      eig  = idle && ifReq[g] && !edg;
      ev   = m_pend[g] && (m_due[g] == cyc);

      chk1($sformatf("u%0d_ifGnt@%0d", g, cyc), ifGnt[g], eig);
      chk1($sformatf("u%0d_dGnt@%0d", g, cyc), dGnt[g], edg);
      chk1($sformatf("u%0d_gnt_excl@%0d", g, cyc), ifGnt[g] & dGnt[g], 1'b0);
      chk1($sformatf("u%0d_memEn@%0d", g, cyc), memEn[g], eig | edg);
      if (eig || edg) begin
        chk32($sformatf("u%0d_memAddr@%0d", g, cyc), 32'(memAddr[g]), 32'(edg ? dAddr[g] : ifAddr[g]));
        chk1($sformatf("u%0d_memWe@%0d", g, cyc), memWe[g], edg && dWe[g]);
        if (edg && dWe[g]) chk32($sformatf("u%0d_memWdata@%0d", g, cyc), memWdata[g], dWdata[g]);
      end
      chk1($sformatf("u%0d_busy@%0d", g, cyc), busy[g], cyc < m_free[g]);
      chk1($sformatf("u%0d_ifValid@%0d", g, cyc), ifValid[g], ev && !m_down[g]);
      chk1($sformatf("u%0d_dValid@%0d", g, cyc), dValid[g], ev && m_down[g]);
      chk1($sformatf("u%0d_valid_excl@%0d", g, cyc), ifValid[g] & dValid[g], 1'b0);
      if (ev && !m_down[g]) chk32($sformatf("u%0d_ifRdata@%0d", g, cyc), ifRdata[g], m_data[g]);
      if (ev && m_down[g])  chk32($sformatf("u%0d_dRdata@%0d", g, cyc), dRdata[g], m_data[g]);

      last_ig[g] = ifGnt[g];
      last_dg[g] = dGnt[g];
      if (ifGnt[g] || dGnt[g]) begin
        last_gnt_cyc[g] = cyc;
        last_we[g]      = memWe[g];
        if (g == 0) glog.push_back(ifGnt[g] ? 8'h49 : 8'h44);
        else if (ifGnt[g]) gcyc1.push_back(cyc);
      end
      if (ifValid[g]) begin
        last_iv_cyc[g] = cyc;
        last_irdata[g] = ifRdata[g];
        if (g == 1) ivcyc1.push_back(cyc);
      end
      if (dValid[g]) begin
        dv_cnt[g]++;
        last_drdata[g] = dRdata[g];
      end

      if (reset) begin
        m_free[g]   = cyc + 1;
        m_pend[g]   = 1'b0;
        m_starve[g] = 0;
      end else begin
        if (!ifReq[g] || eig) m_starve[g] = 0;
        else if (edg && (m_starve[g] < STARVE_MAX)) m_starve[g]++;
        if (ev) m_pend[g] = 1'b0;
        if (eig || edg) begin
          a         = edg ? dAddr[g][7:0] : ifAddr[g][7:0];
          m_free[g] = cyc + lat_of(g) + 2;
          m_due[g]  = cyc + lat_of(g) + 1;
          m_pend[g] = 1'b1;
          m_down[g] = edg;
          if (edg && dWe[g]) begin
            m_data[g]     = '0;
            ref_mem[g][a] = dWdata[g];
          end else begin
            m_data[g] = ref_mem[g][a];
          end
        end
      end

      if (memEn[g] && memWe[g]) env_mem[g][memAddr[g][7:0]] = memWdata[g];
      for (int i = 4; i > 0; i--) dly[g][i] = dly[g][i-1];
      dly[g][0]   = (memEn[g] && !memWe[g]) ? env_mem[g][memAddr[g][7:0]] : $urandom;
      memRdata[g] = dly[g][lat_of(g)];
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic req_fetch(input int g, input logic [15:0] a);
    ifReq[g]  = 1'b1;
    ifAddr[g] = a;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (last_ig[g]) break;
    end
    chk1($sformatf("u%0d_fetch_granted", g), last_ig[g], 1'b1);
    ifReq[g] = 1'b0;
  endtask

  task automatic req_data(input int g, input logic we, input logic [15:0] a, input logic [31:0] wd);
    dReq[g]   = 1'b1;
    dWe[g]    = we;
    dAddr[g]  = a;
    dWdata[g] = wd;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (last_dg[g]) break;
    end
    chk1($sformatf("u%0d_data_granted", g), last_dg[g], 1'b1);
    dReq[g] = 1'b0;
  endtask

  initial begin
    string pat;
    int    dv_save;
    pat   = "DDDDIDDDDIDD";
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      ifReq[g] = 1'b0; ifAddr[g] = '0; dReq[g] = 1'b0; dWe[g] = 1'b0;
      dAddr[g] = '0;   dWdata[g] = '0; memRdata[g] = '0;
      m_free[g] = 0; m_starve[g] = 0; m_due[g] = 0; m_pend[g] = 1'b0; m_down[g] = 1'b0;
      m_data[g] = '0; dv_cnt[g] = 0; last_ig[g] = 1'b0; last_dg[g] = 1'b0; last_we[g] = 1'b0;
      last_gnt_cyc[g] = 0; last_iv_cyc[g] = 0; last_irdata[g] = '0; last_drdata[g] = '0;
      for (int i = 0; i < 5; i++) dly[g][i] = '0;
      for (int i = 0; i < 256; i++) begin
        env_mem[g][i] = $urandom;
        ref_mem[g][i] = env_mem[g][i];
      end
    end
    env_mem[0][3] = 32'd29360128;
    ref_mem[0][3] = 32'd29360128;

    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk1("rst_ifGnt", ifGnt[g], 1'b0);
      chk1("rst_dGnt", dGnt[g], 1'b0);
      chk1("rst_ifValid", ifValid[g], 1'b0);
      chk1("rst_dValid", dValid[g], 1'b0);
      chk1("rst_memEn", memEn[g], 1'b0);
      chk1("rst_memWe", memWe[g], 1'b0);
      chk1("rst_busy", busy[g], 1'b0);
      chk32("rst_ifRdata", ifRdata[g], 32'd0);
      chk32("rst_dRdata", dRdata[g], 32'd0);
    end
    reset = 1'b0;

    // fetch of word 3 at MEM_LAT 1
    req_fetch(0, 16'd3);
    repeat (3) cycle();
    chk32("s1_valid_latency", 32'(last_iv_cyc[0] - last_gnt_cyc[0]), 32'd2);
    chk32("s1_ifRdata", last_irdata[0], 32'd29360128);

    // sw then lw of the same word
    req_data(0, 1'b1, 16'd10, 32'hDEADBEEF);
    chk1("s2_sw_memWe", last_we[0], 1'b1);
    repeat (3) cycle();
    req_data(0, 1'b0, 16'd10, 32'd0);
    repeat (3) cycle();
    chk32("s2_dvalid_count", 32'(dv_cnt[0]), 32'd2);
    chk32("s2_lw_data", last_drdata[0], 32'hDEADBEEF);

    // both requesters held for 12 accesses
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    glog.delete();
    ifAddr[0] = 16'd7; dAddr[0] = 16'd12; dWe[0] = 1'b0;
    ifReq[0]  = 1'b1;  dReq[0]  = 1'b1;
    for (int k = 0; k < 200; k++) begin
      cycle();
      if (glog.size() >= 12) break;
    end
    ifReq[0] = 1'b0;
    dReq[0]  = 1'b0;
    chk32("s3_grant_count", 32'(glog.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < glog.size()) chk32($sformatf("s3_order_%0d", i), 32'(glog[i]), 32'(pat[i]));
    end
    repeat (4) cycle();
`ifdef PERF_CNT_EN
    chk32("s6_ifGrantCnt", ifGrantCnt[0], 32'd2);
    chk32("s6_dGrantCnt", dGrantCnt[0], 32'd10);
    chk32("s6_conflictCnt", conflictCnt[0], 32'd12);
`endif

    // reset while an lw is waiting on memory
    req_data(0, 1'b0, 16'd5, 32'd0);
    dv_save = dv_cnt[0];
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    chk1("s5_dValid", dValid[0], 1'b0);
    chk1("s5_ifValid", ifValid[0], 1'b0);
    chk1("s5_busy", busy[0], 1'b0);
    chk1("s5_memEn", memEn[0], 1'b0);
    chk1("s5_dGnt", dGnt[0], 1'b0);
    chk1("s5_ifGnt", ifGnt[0], 1'b0);
    chk32("s5_dRdata", dRdata[0], 32'd0);
    chk32("s5_ifRdata", ifRdata[0], 32'd0);
    repeat (5) cycle();
    chk32("s5_no_late_dvalid", 32'(dv_cnt[0]), 32'(dv_save));
    req_data(0, 1'b0, 16'd5, 32'd0);
    repeat (3) cycle();
    chk32("s5_serviced", 32'(dv_cnt[0]), 32'(dv_save + 1));
    chk32("s5_lw_data", last_drdata[0], ref_mem[0][5]);

    // back-to-back fetches at MEM_LAT 3
    gcyc1.delete();
    ivcyc1.delete();
    ifAddr[1] = 16'($urandom_range(0, 31));
    ifReq[1]  = 1'b1;
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (last_ig[1]) ifAddr[1] = 16'($urandom_range(0, 31));
      if (gcyc1.size() >= 4) break;
    end
    ifReq[1] = 1'b0;
    repeat (6) cycle();
    chk32("s4_grant_count", 32'(gcyc1.size()), 32'd4);
    chk32("s4_valid_count", 32'(ivcyc1.size()), 32'd4);
    for (int i = 1; i < 4; i++) begin
      if (i < gcyc1.size()) chk32($sformatf("s4_gap_%0d", i), 32'(gcyc1[i] - gcyc1[i-1]), 32'd5);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < gcyc1.size() && i < ivcyc1.size())
        chk32($sformatf("s4_valid_delay_%0d", i), 32'(ivcyc1[i] - gcyc1[i]), 32'd4);
    end

    // randomized traffic on both instances
    for (int k = 0; k < 800; k++) begin
      for (int g = 0; g < 2; g++) begin
        if (ifReq[g] && last_ig[g]) ifReq[g] = 1'b0;
        if (dReq[g] && last_dg[g])  dReq[g]  = 1'b0;
        if (!ifReq[g] && ($urandom_range(0, 2) == 0)) begin
          ifReq[g]  = 1'b1;
          ifAddr[g] = 16'($urandom_range(0, 31));
        end else if (ifReq[g] && ($urandom_range(0, 40) == 0)) begin
          ifReq[g] = 1'b0;
        end
        if (!dReq[g] && ($urandom_range(0, 2) == 0)) begin
          dReq[g]   = 1'b1;
          dWe[g]    = 1'($urandom_range(0, 1));
          dAddr[g]  = 16'($urandom_range(0, 31));
          dWdata[g] = $urandom;
        end else if (dReq[g] && ($urandom_range(0, 40) == 0)) begin
          dReq[g] = 1'b0;
        end
      end
      cycle();
    end
    for (int g = 0; g < 2; g++) begin
      ifReq[g] = 1'b0;
      dReq[g]  = 1'b0;
    end
    repeat (6) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
